// File: rtl/laser_pkg.sv
// laser_pkg: shared sizes, FSM state type and packed point/result records
// used by the LASER point loader and its point buffer.
package laser_pkg;

  localparam int COORD_W = 4;
  localparam int NPTS    = 40;
  localparam int CNT_W   = 6;
  localparam int PT_W    = 2 * COORD_W;

  localparam logic [CNT_W-1:0] NPTS_C = CNT_W'(NPTS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NPTS - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef struct packed {
    logic [COORD_W-1:0] c1x;
    logic [COORD_W-1:0] c1y;
    logic [COORD_W-1:0] c2x;
    logic [COORD_W-1:0] c2y;
  } result_t;

endpackage

// File: rtl/laser_point_buf.sv
// laser_point_buf: NPTS-deep point store with one synchronous write port and
// one combinational read port; all sequencing lives in the loader.
module laser_point_buf
  import laser_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [CNT_W-1:0] waddr_i,
  input  logic [PT_W-1:0]  wdata_i,
  input  logic [CNT_W-1:0] raddr_i,
  output logic [PT_W-1:0]  rdata_o
);

  logic [PT_W-1:0] mem_q [NPTS];

  // NOTE: storage is not reset; the write count alone decides what is valid,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/laser_point_loader.sv
// laser_point_loader: collects NPTS host points, replays them to the solver as a
// one-per-cycle burst and hands back its centres. Optional WAIT abort: LOADER_TIMEOUT_EN.
module laser_point_loader
  import laser_pkg::*;
#(
  parameter int TIMEOUT = 65535
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [COORD_W-1:0] in_x_i,
  input  logic [COORD_W-1:0] in_y_i,
  output logic               sol_rst_o,
  output logic [COORD_W-1:0] sol_x_o,
  output logic [COORD_W-1:0] sol_y_o,
  input  logic               sol_done_i,
  input  logic [COORD_W-1:0] sol_c1x_i,
  input  logic [COORD_W-1:0] sol_c1y_i,
  input  logic [COORD_W-1:0] sol_c2x_i,
  input  logic [COORD_W-1:0] sol_c2y_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [COORD_W-1:0] res_c1x_o,
  output logic [COORD_W-1:0] res_c1y_o,
  output logic [COORD_W-1:0] res_c2x_o,
  output logic [COORD_W-1:0] res_c2y_o,
  output logic               res_err_o,
  output logic               busy_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] rd_addr;
  logic             sol_rst_q, sol_rst_d;
  point_t           sol_pt_q, sol_pt_d;
  point_t           rd_pt;
  logic [PT_W-1:0]  rd_data;
  logic             res_valid_q, res_valid_d;
  result_t          res_q, res_d;
  logic             in_ready;
  logic             in_fire;

`ifdef LOADER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        res_err_q, res_err_d;
`endif

  // Gated by rst_n so the host sees no ready while the block is held in reset.
  assign in_ready = rst_n && (wcnt_q < NPTS_C) && (state_q != STREAM);
  assign in_fire  = in_valid_i && in_ready;
  assign rd_pt    = point_t'(rd_data);

  laser_point_buf u_buf (
    .clk     (clk),
    .we_i    (in_fire),
    .waddr_i (wcnt_q),
    .wdata_i ({in_x_i, in_y_i}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave one
    // unassigned and infer a latch.
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rptr_d      = rptr_q;
    rd_addr     = '0;
    sol_rst_d   = sol_rst_q;
    sol_pt_d    = sol_pt_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
`ifdef LOADER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    res_err_d   = res_err_q;
`endif

    if (in_fire) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        sol_rst_d = 1'b1;
        // An untaken result blocks the next frame even with a full buffer.
        if (wcnt_q == NPTS_C && !res_valid_q) begin
          state_d   = STREAM;
          sol_rst_d = 1'b0;
          rptr_d    = '0;
          sol_pt_d  = rd_pt;
        end
      end

      STREAM: begin
        if (rptr_q == LAST_C) begin
          state_d = WAIT;
          wcnt_d  = '0;
`ifdef LOADER_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          rd_addr  = rptr_q + 1'b1;
          rptr_d   = rd_addr;
          sol_pt_d = rd_pt;
        end
      end

      WAIT: begin
`ifdef LOADER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        if (sol_done_i) begin
          res_d       = result_t'({sol_c1x_i, sol_c1y_i, sol_c2x_i, sol_c2y_i});
          res_valid_d = 1'b1;
          sol_rst_d   = 1'b1;
          state_d     = FILL;
`ifdef LOADER_TIMEOUT_EN
          res_err_d   = 1'b0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          res_d       = '0;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          sol_rst_d   = 1'b1;
          state_d     = FILL;
`endif
        end
      end

      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses <= so each flop samples pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wcnt_q      <= '0;
      rptr_q      <= '0;
      sol_rst_q   <= 1'b1;
      sol_pt_q    <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rptr_q      <= rptr_d;
      sol_rst_q   <= sol_rst_d;
      sol_pt_q    <= sol_pt_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      res_err_q  <= res_err_d;
    end
  end

  assign res_err_o = res_err_q;
`else
  assign res_err_o = 1'b0;
`endif

  assign in_ready_o  = in_ready;
  assign sol_rst_o   = sol_rst_q;
  assign sol_x_o     = sol_pt_q.x;
  assign sol_y_o     = sol_pt_q.y;
  assign res_valid_o = res_valid_q;
  assign res_c1x_o   = res_q.c1x;
  assign res_c1y_o   = res_q.c1y;
  assign res_c2x_o   = res_q.c2x;
  assign res_c2y_o   = res_q.c2y;
  assign busy_o      = (state_q != FILL);

endmodule

// File: tb/tb_laser_point_loader.sv
// tb_laser_point_loader: table vectors for the result handshake, directed corner
// sequences and randomized frames checked against a FIFO-of-frames stream model.
module tb_laser_point_loader;
  import laser_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_x, in_y;
  logic               sol_rst;
  logic [COORD_W-1:0] sol_x, sol_y;
  logic               sol_done;
  logic [COORD_W-1:0] sol_c1x, sol_c1y, sol_c2x, sol_c2y;
  logic               res_valid;
  logic               res_ready;
  logic [COORD_W-1:0] res_c1x, res_c1y, res_c2x, res_c2y;
  logic               res_err;
  logic               busy;
  logic [15:0]        res_cen;

  assign res_cen = {res_c1x, res_c1y, res_c2x, res_c2y};

  always #5 clk = ~clk;

  laser_point_loader #(.TIMEOUT(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_x_i      (in_x),
    .in_y_i      (in_y),
    .sol_rst_o   (sol_rst),
    .sol_x_o     (sol_x),
    .sol_y_o     (sol_y),
    .sol_done_i  (sol_done),
    .sol_c1x_i   (sol_c1x),
    .sol_c1y_i   (sol_c1y),
    .sol_c2x_i   (sol_c2x),
    .sol_c2y_i   (sol_c2y),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_c1x_o   (res_c1x),
    .res_c1y_o   (res_c1y),
    .res_c2x_o   (res_c2x),
    .res_c2y_o   (res_c2y),
    .res_err_o   (res_err),
    .busy_o      (busy)
  );

  int checks   = 0;
  int failures = 0;
  int exp_streams = 0;
  int n_streams   = 0;

  // Reference model: every accepted point, in order; each stream consumes the
  // oldest NPTS of them and must replay them one per cycle, then hold the last.
  logic [7:0] acc_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (in_valid && in_ready) acc_q.push_back({in_x, in_y});
    @(posedge clk);
    #1;
  endtask

  task automatic set_centres(input logic [15:0] c);
    {sol_c1x, sol_c1y, sol_c2x, sol_c2y} = c;
  endtask

  // Stream monitor, sampled on the falling edge.
  logic [7:0] frame [NPTS];
  int   sidx    = -1;
  int   kidx;
  logic prev_rst = 1'b1;
  logic prev_rv  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sidx     = -1;
      prev_rst = 1'b1;
      prev_rv  = 1'b0;
    end else begin
      if (prev_rst && !sol_rst) begin
        n_streams++;
        check("start_while_result", 32'(prev_rv), 32'd0);
        check("frame_available", 32'(acc_q.size() >= NPTS), 32'd1);
        for (int i = 0; i < NPTS; i++) frame[i] = (acc_q.size() > 0) ? acc_q.pop_front() : 8'hxx;
        sidx = 0;
      end
      if (sidx >= 0) begin
        kidx = (sidx < NPTS) ? sidx : NPTS - 1;
        check($sformatf("stream_pt%0d", sidx), 32'({sol_x, sol_y}), 32'(frame[kidx]));
        if (sidx < NPTS) begin
          check("ready_in_stream", 32'(in_ready), 32'd0);
          check("busy_in_stream", 32'(busy), 32'd1);
        end
        sidx = (sidx == NPTS) ? -1 : sidx + 1;
      end
      prev_rst = sol_rst;
      prev_rv  = res_valid;
    end
  end

  task automatic load_frame(input bit basic, input bit gappy);
    int k = 0;
    int guard = 0;
    while (k < NPTS && guard < 4000) begin
      in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_x = basic ? COORD_W'(k % 16) : COORD_W'($urandom);
      in_y = basic ? COORD_W'(k / 16) : COORD_W'($urandom);
      if (in_valid && in_ready) k++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("load_accepts", 32'(k), 32'(NPTS));
    check("full_ready", 32'(in_ready), 32'd0);
  endtask

  // Called right after the last accept while in FILL with no result pending.
  task automatic expect_start(input string tag);
    check({tag, "_rst_before"}, 32'(sol_rst), 32'd1);
    tick();
    check({tag, "_rst_fall"}, 32'(sol_rst), 32'd0);
    exp_streams++;
    repeat (NPTS) tick();
    check({tag, "_wait_busy"}, 32'(busy), 32'd1);
    check({tag, "_wait_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic finish_frame(input logic [15:0] c, input int dd, input int rd);
    for (int i = 0; i < dd; i++) tick();
    check("pre_done_valid", 32'(res_valid), 32'd0);
    sol_done = 1'b1;
    set_centres(c);
    tick();
    sol_done = 1'b0;
    set_centres(~c);
    check("res_valid_rise", 32'(res_valid), 32'd1);
    check("res_centres", 32'(res_cen), 32'(c));
    check("res_err_clear", 32'(res_err), 32'd0);
    check("done_sol_rst", 32'(sol_rst), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    for (int i = 0; i < rd; i++) tick();
    check("res_hold_centres", 32'(res_cen), 32'(c));
    check("res_hold_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_fall", 32'(res_valid), 32'd0);
  endtask

  typedef struct {
    logic        done;
    logic        rdy;
    logic [15:0] cen;
    logic        e_valid;
    logic [15:0] e_cen;
    logic        e_busy;
    logic        e_rst;
    logic        chk_cen;
  } vec_t;

  vec_t vecs [7];
  int   fires;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    // Applied from WAIT right after the basic frame: result latency, hold,
    // SOL_DONE ignored outside WAIT, and the release handshake.
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h34AC, 1'b1, 16'h34AC, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h1111, 1'b1, 16'h34AC, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h34AC, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0;
    sol_done = 1'b0; set_centres(16'h0); res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sol_rst", 32'(sol_rst), 32'd1);
    check("rst_sol_xy", 32'({sol_x, sol_y}), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_cen", 32'(res_cen), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Basic frame: (k mod 16, k/16), IN_VALID held high.
    load_frame(1'b1, 1'b0);
    expect_start("basic");
    check("basic_hold_p39", 32'({sol_x, sol_y}), 32'h72);
    for (int i = 0; i < 7; i++) begin
      sol_done  = vecs[i].done;
      res_ready = vecs[i].rdy;
      set_centres(vecs[i].cen);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(res_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_sol_rst", i), 32'(sol_rst), 32'(vecs[i].e_rst));
      if (vecs[i].chk_cen) check($sformatf("vec%0d_cen", i), 32'(res_cen), 32'(vecs[i].e_cen));
    end
    sol_done = 1'b0; res_ready = 1'b0;

    // Backpressure: refill during WAIT, keep the result untaken.
    load_frame(1'b0, 1'b0);
    expect_start("bpA");
    load_frame(1'b0, 1'b0);
    check("bp_refill_busy", 32'(busy), 32'd1);
    sol_done = 1'b1;
    set_centres(16'h5A3C);
    tick();
    sol_done = 1'b0;
    check("bp_res_valid", 32'(res_valid), 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_x = COORD_W'($urandom);
      in_y = COORD_W'($urandom);
      tick();
      check("bp_hold_sol_rst", 32'(sol_rst), 32'd1);
    end
    in_valid = 1'b0;
    check("bp_hold_cen", 32'(res_cen), 32'h5A3C);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_valid_fall", 32'(res_valid), 32'd0);
    check("bp_rst_still", 32'(sol_rst), 32'd1);
    tick();
    exp_streams++;
    check("bp_stream_start", 32'(sol_rst), 32'd0);
    repeat (NPTS) tick();
    check("bp_wait_busy", 32'(busy), 32'd1);
    finish_frame(16'hC3E1, 2, 1);

    // Gapped input, IN_VALID kept toggling through STREAM.
    fires = 0;
    for (int c = 0; c < 120; c++) begin
      in_valid = (c % 2 == 0);
      in_x = COORD_W'($urandom);
      in_y = COORD_W'($urandom);
      if (in_valid && in_ready) fires++;
      tick();
    end
    in_valid = 1'b0;
    exp_streams++;
    check("gap_writes", 32'(fires), 32'(NPTS));
    check("gap_wait_busy", 32'(busy), 32'd1);
    check("gap_wait_sol_rst", 32'(sol_rst), 32'd0);
    finish_frame(16'($urandom), 0, 0);

    // Randomized frames.
    for (int f = 0; f < 5; f++) begin
      load_frame(1'b0, 1'b1);
      expect_start("rnd");
      finish_frame(16'($urandom), $urandom_range(0, 6), $urandom_range(0, 4));
    end

    // Reset in the middle of STREAM.
    load_frame(1'b0, 1'b0);
    tick();
    exp_streams++;
    check("mid_stream_start", 32'(sol_rst), 32'd0);
    repeat (20) tick();
    rst_n = 1'b0;
    acc_q.delete();
    #1;
    check("mid_rst_sol_rst", 32'(sol_rst), 32'd1);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready_after", 32'(in_ready), 32'd1);
    load_frame(1'b0, 1'b0);
    expect_start("clean");
    finish_frame(16'h9999, 1, 0);

`ifdef LOADER_TIMEOUT_EN
    load_frame(1'b0, 1'b0);
    expect_start("tmo");
    repeat (99) tick();
    check("tmo_not_yet", 32'(res_valid), 32'd0);
    tick();
    check("tmo_valid", 32'(res_valid), 32'd1);
    check("tmo_err", 32'(res_err), 32'd1);
    check("tmo_cen_zero", 32'(res_cen), 32'd0);
    check("tmo_sol_rst", 32'(sol_rst), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("tmo_valid_fall", 32'(res_valid), 32'd0);

    load_frame(1'b0, 1'b0);
    expect_start("tie");
    repeat (99) tick();
    sol_done = 1'b1;
    set_centres(16'h34AC);
    tick();
    sol_done = 1'b0;
    set_centres(16'h0);
    check("tie_valid", 32'(res_valid), 32'd1);
    check("tie_err", 32'(res_err), 32'd0);
    check("tie_cen", 32'(res_cen), 32'h34AC);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`else
    load_frame(1'b0, 1'b0);
    expect_start("nowait");
    repeat (300) tick();
    check("nowait_valid", 32'(res_valid), 32'd0);
    check("nowait_busy", 32'(busy), 32'd1);
    check("nowait_err", 32'(res_err), 32'd0);
    finish_frame(16'h7E21, 0, 0);
`endif

    repeat (3) tick();
    check("stream_count", 32'(n_streams), 32'(exp_streams));
    check("monitor_idle", 32'(sidx), 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
